// File: rtl/button_conditioner.sv
// button_conditioner: sync + debounce + press/release pulses per button; optional auto-repeat via BUTTON_AUTO_REPEAT_EN
module button_conditioner #(
  parameter int unsigned N_BTN         = 6,
  parameter int unsigned DEBOUNCE_CYC  = 1250000,
  parameter int unsigned REPEAT_MASK   = 'b011000,
  parameter int unsigned REPEAT_DELAY  = 62500000,
  parameter int unsigned REPEAT_PERIOD = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CTERM = CW'(DEBOUNCE_CYC - 1);

  if (DEBOUNCE_CYC < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || (REPEAT_MASK >> N_BTN) != 0) begin : g_bad_cfg
    $error("button_conditioner: illegal parameter set");
  end

  logic [N_BTN-1:0] s1_q, s2_q, level_q, level_d, press_q, release_q, rep_fire;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];

  // Debounce: level follows s2 only after DEBOUNCE_CYC consecutive mismatching cycles
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i]   = (s2_q[i] == level_q[i] || cnt_q[i] == CTERM) ? '0 : cnt_q[i] + 1'b1;
      level_d[i] = (s2_q[i] != level_q[i] && cnt_q[i] == CTERM) ? s2_q[i] : level_q[i];
    end
  end

  // Synchroniser, debounce state and registered edge pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= (level_d & ~level_q) | rep_fire;
      release_q <= ~level_d & level_q;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPER = RW'(REPEAT_PERIOD);

  logic [RW-1:0]    rcnt_q [N_BTN];
  logic [RW-1:0]    rcnt_d [N_BTN];
  logic [N_BTN-1:0] rhold, rfirst_q, rfirst_d;

  // Repeat timer: runs while a masked level stays high; first wait is DELAY, later waits PERIOD
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      rhold[i]    = REPEAT_MASK[i] && level_q[i] && level_d[i];
      rep_fire[i] = rhold[i] && (rcnt_q[i] + 1'b1) == (rfirst_q[i] ? RPER : RDLY);
      rcnt_d[i]   = (!rhold[i] || rep_fire[i]) ? '0 : rcnt_q[i] + 1'b1;
      rfirst_d[i] = rhold[i] && (rfirst_q[i] || rep_fire[i]);
    end
  end

  // Repeat timer state
  always_ff @(posedge clk) begin
    if (reset) begin
      rfirst_q <= '0;
      for (int i = 0; i < N_BTN; i++) rcnt_q[i] <= '0;
    end else begin
      rfirst_q <= rfirst_d;
      for (int i = 0; i < N_BTN; i++) rcnt_q[i] <= rcnt_d[i];
    end
  end
`else
  assign rep_fire = '0;
`endif

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
endmodule
